mult_scheduler: RTL and testbench

MULT_SCHEDULER -- requirements
Module: mult_scheduler

---
 rtl/mult_scheduler_pkg.sv | 33 +++
 rtl/mult_pipe.sv | 69 ++++++
 rtl/mult_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_mult_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_scheduler_pkg.sv
// Shared types and constants for the time-shared multiplier scheduler.
// Optional feature: define MULT_SCHEDULER_SAT_EN to saturate results whose
// dropped product MSBs disagree instead of wrapping them.
package mult_scheduler_pkg;

  localparam int DEF_BITSIZE     = 16;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_MUL_LATENCY = 1;

  // Scheduler states for one frame of work.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Upper bit of the Q1.(w-1) result within the 2*w-bit full product.
  function automatic int prod_msb(input int w);
    return 2 * w - 2;
  endfunction

  // Lower bit of the Q1.(w-1) result within the 2*w-bit full product.
  function automatic int prod_lsb(input int w);
    return w - 1;
  endfunction

  // Width of a requester index; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_pipe.sv
// Signed BITSIZE x BITSIZE multiplier with MUL_LATENCY register stages.
// The requester index and a valid bit travel alongside each product so the
// scheduler knows which result slot to update when the product emerges.
module mult_pipe
  import mult_scheduler_pkg::*;
#(
  parameter int BITSIZE     = DEF_BITSIZE,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int IDXW        = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [IDXW-1:0]        in_idx,
  input  logic [BITSIZE-1:0]     in_a,
  input  logic [BITSIZE-1:0]     in_b,
  output logic                   out_valid,
  output logic [IDXW-1:0]        out_idx,
  output logic [2*BITSIZE-1:0]   out_prod
);

  localparam int PW = 2 * BITSIZE;

  logic signed [PW-1:0] prod_s;
  logic [PW-1:0]        prod_d  [MUL_LATENCY];
  logic [PW-1:0]        prod_q  [MUL_LATENCY];
  logic [IDXW-1:0]      idx_d   [MUL_LATENCY];
  logic [IDXW-1:0]      idx_q   [MUL_LATENCY];
  logic [MUL_LATENCY-1:0] valid_d;
  logic [MUL_LATENCY-1:0] valid_q;

  // Full-width signed product; operands are sign-extended so the 2*BITSIZE result is exact.
  always_comb begin
    prod_s = $signed({{BITSIZE{in_a[BITSIZE-1]}}, in_a}) *
             $signed({{BITSIZE{in_b[BITSIZE-1]}}, in_b});
  end

  // Next-state of the stage chain: stage 0 takes the new product, later stages shift.
  always_comb begin
    prod_d[0]  = prod_s;
    idx_d[0]   = in_idx;
    valid_d[0] = in_valid;
    for (int k = 1; k < MUL_LATENCY; k++) begin
      prod_d[k]  = prod_q[k-1];
      idx_d[k]   = idx_q[k-1];
      valid_d[k] = valid_q[k-1];
    end
  end

  // Stage registers; reset empties the pipe so in-flight products are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MUL_LATENCY; k++) begin
        prod_q[k] <= '0;
        idx_q[k]  <= '0;
      end
      valid_q <= '0;
    end else begin
      prod_q  <= prod_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q[MUL_LATENCY-1];
  assign out_idx   = idx_q[MUL_LATENCY-1];
  assign out_prod  = prod_q[MUL_LATENCY-1];

endmodule

// File: rtl/mult_scheduler.sv
// Frame-driven scheduler sharing one pipelined multiplier among NUM_REQ
// requesters. On each lrclk rising edge the valid requesters are captured and
// issued lowest index first, one per bclk; results land in registered slots.
// Optional feature: MULT_SCHEDULER_SAT_EN selects saturation of out-of-range
// Q1 results (only -1 x -1); without it the result wraps by bit slicing.
module mult_scheduler
  import mult_scheduler_pkg::*;
#(
  parameter int BITSIZE     = DEF_BITSIZE,
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
  input  logic                       bclk,
  input  logic                       rst_n,
  input  logic                       lrclk,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*BITSIZE-1:0] req_a,
  input  logic [NUM_REQ*BITSIZE-1:0] req_b,
  output logic [NUM_REQ*BITSIZE-1:0] res_data,
  output logic [NUM_REQ-1:0]         res_valid,
  output logic                       frame_done,
  output logic                       overrun,
  input  logic                       overrun_clr
);

  localparam int IDXW  = idx_width(NUM_REQ);
  localparam int PW    = 2 * BITSIZE;
  localparam int P_MSB = prod_msb(BITSIZE);
  localparam int P_LSB = prod_lsb(BITSIZE);
  localparam logic [1:0] DRAIN_INIT = 2'(MUL_LATENCY - 1);

  // lrclk synchroniser: bit0/bit1 are the two sync flops, bit2 the edge-detect history.
  logic [2:0]               sync_d, sync_q;
  logic                     frame_start_s;

  state_e                   state_d, state_q;
  logic [NUM_REQ-1:0]       pend_d, pend_q;
  logic [1:0]               drain_d, drain_q;
  logic                     overrun_d, overrun_q;
  logic                     frame_done_d, frame_done_q;
  logic [NUM_REQ*BITSIZE-1:0] res_data_d, res_data_q;
  logic [NUM_REQ-1:0]       res_valid_d, res_valid_q;

  logic                     issue_valid_s;
  logic [NUM_REQ-1:0]       issue_onehot_s;
  logic [IDXW-1:0]          issue_idx_s;
  logic [BITSIZE-1:0]       issue_a_s;
  logic [BITSIZE-1:0]       issue_b_s;

  logic                     pipe_valid_s;
  logic [IDXW-1:0]          pipe_idx_s;
  logic [PW-1:0]            pipe_prod_s;
  logic [BITSIZE-1:0]       slice_s;
  logic [NUM_REQ-1:0]       res_hit_s;
  logic                     unused_prod_s;

  // Shift lrclk through the synchroniser and flag its rising edge.
  always_comb begin
    sync_d        = {sync_q[1:0], lrclk};
    frame_start_s = sync_q[1] & ~sync_q[2];
  end

  // Pick the lowest-index pending requester and its operands for this cycle.
  always_comb begin
    issue_valid_s  = (state_q == ST_ISSUE);
    issue_onehot_s = '0;
    issue_idx_s    = '0;
    issue_a_s      = '0;
    issue_b_s      = '0;
    // Scan downwards so the last (lowest) pending index wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      issue_onehot_s = pend_q[i] ? (NUM_REQ'(1) << i) : issue_onehot_s;
      issue_idx_s    = pend_q[i] ? IDXW'(i) : issue_idx_s;
      issue_a_s      = pend_q[i] ? req_a[i*BITSIZE +: BITSIZE] : issue_a_s;
      issue_b_s      = pend_q[i] ? req_b[i*BITSIZE +: BITSIZE] : issue_b_s;
    end
  end

  // Frame FSM: snapshot, issue, drain the pipe, then signal completion.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    drain_d   = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start_s) begin
          pend_d  = req_valid;
          state_d = (req_valid == '0) ? ST_DONE : ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        pend_d = pend_q & ~issue_onehot_s;
        if (pend_d == '0) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'd0) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = '0;
        drain_d = 2'd0;
      end
    endcase
    frame_done_d = (state_d == ST_DONE);
  end

  // Sticky overrun: a frame start outside IDLE is dropped and flagged; set beats clear.
  always_comb begin
    if (frame_start_s && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Reduce the full product to a Q1 result, optionally saturating -1 x -1.
  always_comb begin
`ifdef MULT_SCHEDULER_SAT_EN
    if (pipe_prod_s[PW-1] != pipe_prod_s[P_MSB]) begin
      slice_s = pipe_prod_s[PW-1] ? {1'b1, {(BITSIZE-1){1'b0}}}
                                  : {1'b0, {(BITSIZE-1){1'b1}}};
    end else begin
      slice_s = pipe_prod_s[P_MSB:P_LSB];
    end
`else
    slice_s = pipe_prod_s[P_MSB:P_LSB];
`endif
    unused_prod_s = ^{pipe_prod_s[PW-1], pipe_prod_s[P_LSB-1:0]};
  end

  // Route the emerging product to its slot; other slots keep their value.
  always_comb begin
    res_data_d  = res_data_q;
    res_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      res_hit_s[i]                     = pipe_valid_s && (pipe_idx_s == IDXW'(i));
      res_valid_d[i]                   = res_hit_s[i];
      res_data_d[i*BITSIZE +: BITSIZE] = res_hit_s[i] ? slice_s
                                                      : res_data_q[i*BITSIZE +: BITSIZE];
    end
  end

  // All scheduler state and registered outputs.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 3'b000;
      state_q      <= ST_IDLE;
      pend_q       <= '0;
      drain_q      <= 2'd0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
      res_data_q   <= '0;
      res_valid_q  <= '0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      pend_q       <= pend_d;
      drain_q      <= drain_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
    end
  end

  mult_pipe #(
    .BITSIZE     (BITSIZE),
    .MUL_LATENCY (MUL_LATENCY),
    .IDXW        (IDXW)
  ) u_pipe (
    .clk       (bclk),
    .rst_n     (rst_n),
    .in_valid  (issue_valid_s),
    .in_idx    (issue_idx_s),
    .in_a      (issue_a_s),
    .in_b      (issue_b_s),
    .out_valid (pipe_valid_s),
    .out_idx   (pipe_idx_s),
    .out_prod  (pipe_prod_s)
  );

  assign res_data   = res_data_q;
  assign res_valid  = res_valid_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Scoreboard bench for mult_scheduler: stimulus pushes expected results and
// their arrival cycles; a negedge monitor pops and compares.
module tb_mult_scheduler;

  localparam int W = 16;
  localparam int N = 4;
  localparam int L = 1;

  logic             bclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             lrclk = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [N*W-1:0]   res_data;
  logic [N-1:0]     res_valid;
  logic             frame_done;
  logic             overrun;
  logic             overrun_clr = 1'b0;

  typedef struct {
    int          idx;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          fd_q[$];
  logic [15:0] res_model [N];
  exp_t        mon_e;
  int          mon_fd;
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;

  mult_scheduler #(.BITSIZE(W), .NUM_REQ(N), .MUL_LATENCY(L)) dut (
    .bclk        (bclk),
    .rst_n       (rst_n),
    .lrclk       (lrclk),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .res_data    (res_data),
    .res_valid   (res_valid),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 bclk = ~bclk;
  always @(posedge bclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Q1.15 product: exact integer product scaled down by 2^15 with floor,
  // then either clamped to the representable range or wrapped to 16 bits.
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> 15;
`ifdef MULT_SCHEDULER_SAT_EN
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
`endif
    return p[15:0];
  endfunction

  function automatic logic [N*W-1:0] model_vec();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = res_model[i];
    return v;
  endfunction

  // Monitor: every result pulse and frame_done pulse must match the scoreboard.
  always @(negedge bclk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (res_valid[i]) begin
          if (exp_q.size() == 0) begin
            check("res_unexpected", 64'(i), 64'hFF);
          end else begin
            mon_e = exp_q.pop_front();
            check("res_idx", 64'(i), 64'(mon_e.idx));
            check("res_data", 64'(res_data[i*W +: W]), 64'(mon_e.data));
            check("res_cycle", 64'(cyc), 64'(mon_e.cyc));
            res_model[mon_e.idx] = mon_e.data;
          end
        end
      end
      if (|res_valid) check("res_all_slots", 64'(res_data), 64'(model_vec()));
      if (frame_done) begin
        if (fd_q.size() == 0) begin
          check("frame_done_unexpected", 64'(frame_done), 64'h0);
        end else begin
          mon_fd = fd_q.pop_front();
          check("frame_done_cycle", 64'(cyc), 64'(mon_fd));
        end
      end
    end
  end

  // One frame: push expectations, raise lrclk (optionally twice), wait it out.
  task automatic run_frame(input logic [N-1:0] mask, input logic [N*W-1:0] a,
                           input logic [N*W-1:0] b, input bit scramble, input bit dbl);
    int r;
    int k;
    @(negedge bclk);
    req_valid = mask;
    req_a     = a;
    req_b     = b;
    lrclk     = 1'b1;
    r = cyc + 1;
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        exp_q.push_back('{i, ref_mul(a[i*W +: W], b[i*W +: W]), r + 3 + k + L});
        k++;
      end
    end
    fd_q.push_back((k == 0) ? r + 2 : r + 2 + k + L);
    if (dbl) begin
      @(negedge bclk); lrclk = 1'b0;
      @(negedge bclk); lrclk = 1'b1;
      @(negedge bclk);
    end else begin
      repeat (3) @(negedge bclk);
    end
    if (scramble) req_valid = N'($urandom);
    repeat (2) @(negedge bclk);
    lrclk = 1'b0;
    repeat (12) @(negedge bclk);
    check("results_drained", 64'(exp_q.size()), 64'h0);
    check("frame_done_seen", 64'(fd_q.size()), 64'h0);
    check("res_data_final", 64'(res_data), 64'(model_vec()));
  endtask

  function automatic logic [N*W-1:0] rand_ops();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*W +: W] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
    return v;
  endfunction

  initial begin
    int r;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    for (int i = 0; i < N; i++) res_model[i] = 16'h0000;

    repeat (3) @(negedge bclk);
    check("reset_res_data", 64'(res_data), 64'h0);
    check("reset_res_valid", 64'(res_valid), 64'h0);
    check("reset_frame_done", 64'(frame_done), 64'h0);
    check("reset_overrun", 64'(overrun), 64'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge bclk);

    // Single requester, 0.5 x 0.5.
    a = '0; b = '0;
    a[15:0] = 16'h4000; b[15:0] = 16'h4000;
    run_frame(4'b0001, a, b, 1'b0, 1'b0);
    check("half_times_half", 64'(res_data[15:0]), 64'h2000);

    // All four requesters, back-to-back issue. 0x7FFF*0xC000 = 0xE0004000, slice [30:15] = 0xC000.
    a = {4{16'h7FFF}}; b = {4{16'hC000}};
    run_frame(4'b1111, a, b, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) check("all_four_slot", 64'(res_data[i*W +: W]), 64'hC000);

    // -1 x -1 corner.
    a = res_data; b = res_data;
    a[15:0] = 16'h8000; b[15:0] = 16'h8000;
    run_frame(4'b0001, a, b, 1'b0, 1'b0);
`ifdef MULT_SCHEDULER_SAT_EN
    check("minus_one_squared", 64'(res_data[15:0]), 64'h7FFF);
`else
    check("minus_one_squared", 64'(res_data[15:0]), 64'h8000);
`endif

    // Empty frame: only frame_done, slots untouched.
    run_frame(4'b0000, rand_ops(), rand_ops(), 1'b0, 1'b0);

    // Second frame start during ISSUE is dropped and flagged.
    run_frame(4'b1111, rand_ops(), rand_ops(), 1'b0, 1'b1);
    check("overrun_set", 64'(overrun), 64'h1);
    repeat (3) @(negedge bclk);
    check("overrun_sticky", 64'(overrun), 64'h1);
    overrun_clr = 1'b1;
    @(negedge bclk);
    overrun_clr = 1'b0;
    check("overrun_cleared", 64'(overrun), 64'h0);

    // Random frames with req_valid disturbed after the snapshot.
    for (int f = 0; f < 25; f++) begin
      run_frame(N'($urandom), rand_ops(), rand_ops(), 1'b1, 1'b0);
    end

    // Reset while the last product is still draining.
    @(negedge bclk);
    req_valid = 4'b1111;
    a = rand_ops(); b = rand_ops();
    req_a = a; req_b = b;
    lrclk = 1'b1;
    r = cyc + 1;
    for (int i = 0; i < N; i++)
      exp_q.push_back('{i, ref_mul(a[i*W +: W], b[i*W +: W]), r + 4 + i});
    fd_q.push_back(r + 7);
    repeat (3) @(negedge bclk);
    lrclk = 1'b0;
    repeat (4) @(negedge bclk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_res_data", 64'(res_data), 64'h0);
    check("rst_res_valid", 64'(res_valid), 64'h0);
    check("rst_frame_done", 64'(frame_done), 64'h0);
    check("rst_overrun", 64'(overrun), 64'h0);
    check("rst_inflight_left", 64'(exp_q.size()), 64'h1);
    exp_q.delete();
    fd_q.delete();
    for (int i = 0; i < N; i++) res_model[i] = 16'h0000;
    repeat (3) @(negedge bclk);
    rst_n = 1'b1;
    repeat (15) @(negedge bclk);
    check("post_rst_res_data", 64'(res_data), 64'h0);
    check("post_rst_overrun", 64'(overrun), 64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
